// File: rtl/wr_burst_drain_pkg.sv
// Shared definitions for the write-burst drain stage: FIFO entry layout,
// buffered beat payload and FSM state encoding.
package wr_burst_drain_pkg;

  localparam int unsigned DATA_W   = 32;
  localparam int unsigned BE_W     = 4;
  localparam int unsigned BEAT_W   = DATA_W + BE_W;
  localparam int unsigned DATA_LSB = 0;
  localparam int unsigned ADDR_LSB = DATA_W;

  // Byte enables sit above the address field, so their offset depends on AW.
  function automatic int unsigned be_lsb(int unsigned aw);
    return ADDR_LSB + aw;
  endfunction

  function automatic int unsigned entry_w(int unsigned aw);
    return BE_W + aw + DATA_W;
  endfunction

  typedef enum logic [1:0] {
    ST_IDLE    = 2'd0,
    ST_COLLECT = 2'd1,
    ST_ISSUE   = 2'd2
  } state_t;

  typedef struct packed {
    logic [BE_W-1:0]   be;
    logic [DATA_W-1:0] data;
  } beat_t;

endpackage

// File: rtl/wr_burst_buf.sv
// Register buffer holding the beats of the burst being gathered;
// synchronous indexed write, asynchronous indexed read.
module wr_burst_buf
  import wr_burst_drain_pkg::*;
#(
  parameter int unsigned DEPTH = 4,
  parameter int unsigned IDX_W = 2
) (
  input  logic              clk,
  input  logic              wr_en,
  input  logic [IDX_W-1:0]  wr_idx,
  input  logic [BEAT_W-1:0] wr_data,
  input  logic [IDX_W-1:0]  rd_idx,
  output logic [BEAT_W-1:0] rd_data
);

  logic [BEAT_W-1:0] mem [DEPTH];

  always_ff @(posedge clk) begin
    if (wr_en) mem[wr_idx] <= wr_data;
  end

  assign rd_data = mem[rd_idx];

endmodule

// File: rtl/wr_burst_drain.sv
// Pops CPU write-FIFO entries, gathers runs of consecutive word addresses
// and issues each run as one Avalon-MM write burst.
module wr_burst_drain
  import wr_burst_drain_pkg::*;
#(
  parameter int unsigned AW        = 30,
  parameter int unsigned MAX_BURST = 4,
  parameter int unsigned TIMEOUT   = 3
) (
  input  logic                   clk,
  input  logic                   rst,
  input  logic [entry_w(AW)-1:0] fifo_q,
  input  logic                   fifo_empty,
  output logic                   fifo_rdreq,
  input  logic                   flush,
  output logic                   drained,
  output logic [AW-1:0]          avm_address,
  output logic [31:0]            avm_writedata,
  output logic [3:0]             avm_byteenable,
  output logic [3:0]             avm_burstcount,
  output logic                   avm_write,
  input  logic                   avm_waitrequest
);

  localparam int unsigned IDX_W  = (MAX_BURST > 1) ? $clog2(MAX_BURST) : 1;
  localparam int unsigned CNT_W  = 4;
  localparam int unsigned IDLE_W = (TIMEOUT > 0) ? $clog2(TIMEOUT + 1) : 1;
  localparam int unsigned BE_POS = be_lsb(AW);

  state_t            state, state_nxt;
  logic [AW-1:0]     base, base_nxt;
  logic [CNT_W-1:0]  count, count_nxt;
  logic [CNT_W-1:0]  beat, beat_nxt;
  logic [IDLE_W-1:0] idle_cnt, idle_nxt;

  logic [AW-1:0]     head_addr;
  beat_t             head_beat;
  beat_t             rd_beat;
  logic [AW-1:0]     next_addr;
  logic              full;
  logic              boundary;
  logic [CNT_W-1:0]  last_beat;
  logic              buf_we;
  logic [IDX_W-1:0]  buf_widx;

  assign head_addr = fifo_q[ADDR_LSB +: AW];
  assign head_beat = {fifo_q[BE_POS +: BE_W], fifo_q[DATA_LSB +: DATA_W]};

  // Address wrap needs no special case: the alignment check closes the
  // burst before it could cross a MAX_BURST-aligned boundary.
  assign next_addr = base + AW'(count);
  assign boundary  = (next_addr & AW'(MAX_BURST - 1)) == '0;
  assign full      = (count == CNT_W'(MAX_BURST));
  assign last_beat = count - CNT_W'(1);

  wr_burst_buf #(
    .DEPTH (MAX_BURST),
    .IDX_W (IDX_W)
  ) u_buf (
    .clk     (clk),
    .wr_en   (buf_we),
    .wr_idx  (buf_widx),
    .wr_data (head_beat),
    .rd_idx  (beat[IDX_W-1:0]),
    .rd_data (rd_beat)
  );

  always_ff @(posedge clk) begin
    if (rst) begin
      state    <= ST_IDLE;
      base     <= '0;
      count    <= '0;
      beat     <= '0;
      idle_cnt <= '0;
    end else begin
      state    <= state_nxt;
      base     <= base_nxt;
      count    <= count_nxt;
      beat     <= beat_nxt;
      idle_cnt <= idle_nxt;
    end
  end

  always_comb begin
    state_nxt  = state;
    base_nxt   = base;
    count_nxt  = count;
    beat_nxt   = beat;
    idle_nxt   = idle_cnt;
    fifo_rdreq = 1'b0;
    buf_we     = 1'b0;
    buf_widx   = '0;
    case (state)
      ST_IDLE: begin
        if (!fifo_empty) begin
          fifo_rdreq = 1'b1;
          buf_we     = 1'b1;
          base_nxt   = head_addr;
          count_nxt  = CNT_W'(1);
          idle_nxt   = '0;
          state_nxt  = ST_COLLECT;
        end
      end
      ST_COLLECT: begin
        if (flush || full || boundary) begin
          state_nxt = ST_ISSUE;
        end else if (!fifo_empty) begin
          // A non-consecutive head stays in the FIFO to open the next burst.
          if (head_addr == next_addr) begin
            fifo_rdreq = 1'b1;
            buf_we     = 1'b1;
            buf_widx   = count[IDX_W-1:0];
            count_nxt  = count + CNT_W'(1);
            idle_nxt   = '0;
          end else begin
            state_nxt = ST_ISSUE;
          end
        end else begin
          idle_nxt = idle_cnt + IDLE_W'(1);
          if (idle_nxt == IDLE_W'(TIMEOUT)) state_nxt = ST_ISSUE;
        end
      end
      ST_ISSUE: begin
        if (!avm_waitrequest) begin
          if (beat == last_beat) begin
            beat_nxt  = '0;
            state_nxt = ST_IDLE;
          end else begin
            beat_nxt = beat + CNT_W'(1);
          end
        end
      end
      default: state_nxt = ST_IDLE;
    endcase
  end

  // Bus outputs come only from registered state and the buffer, gated to zero outside ISSUE.
  assign avm_write      = (state == ST_ISSUE);
  assign avm_address    = avm_write ? base : '0;
  assign avm_burstcount = avm_write ? count : '0;
  assign avm_writedata  = avm_write ? rd_beat.data : '0;
  assign avm_byteenable = avm_write ? rd_beat.be : '0;
  assign drained        = (state == ST_IDLE) && fifo_empty;

endmodule

// File: tb/tb_wr_burst_drain.sv
// Bench for wr_burst_drain: show-ahead FIFO model, table of burst-grouping
// vectors with an expected-beat scoreboard, plus a mid-burst reset sequence.
module tb_wr_burst_drain;

  localparam int unsigned AW = 30;
  localparam int unsigned EW = AW + 36;

  logic          clk = 1'b0;
  logic          rst;
  logic [EW-1:0] fifo_q;
  logic          fifo_empty;
  logic          fifo_rdreq;
  logic          flush;
  logic          drained;
  logic [AW-1:0] avm_address;
  logic [31:0]   avm_writedata;
  logic [3:0]    avm_byteenable;
  logic [3:0]    avm_burstcount;
  logic          avm_write;
  logic          avm_waitrequest;

  wr_burst_drain #(.AW(AW), .MAX_BURST(4), .TIMEOUT(3)) dut (
    .clk             (clk),
    .rst             (rst),
    .fifo_q          (fifo_q),
    .fifo_empty      (fifo_empty),
    .fifo_rdreq      (fifo_rdreq),
    .flush           (flush),
    .drained         (drained),
    .avm_address     (avm_address),
    .avm_writedata   (avm_writedata),
    .avm_byteenable  (avm_byteenable),
    .avm_burstcount  (avm_burstcount),
    .avm_write       (avm_write),
    .avm_waitrequest (avm_waitrequest)
  );

  always #5 clk = ~clk;

  typedef struct packed {
    logic [AW-1:0] addr;
    logic [3:0]    bc;
    logic [3:0]    be;
    logic [31:0]   data;
  } exp_t;

  typedef struct {
    int unsigned       n;
    logic [3:0][AW-1:0] addr;
    int unsigned       nb;
    logic [3:0][3:0]   bc;
    logic [3:0]        stall;
    logic              flush;
    int unsigned       lat;
    int unsigned       wcyc;
  } vec_t;

  logic [EW-1:0] fq[$];
  exp_t          sb[$];
  vec_t          vecs[10];
  int            n_cmp = 0;
  int            n_bad = 0;
  logic [3:0]    be_ctr = 4'h0;

  task automatic chk(input string name, input logic [127:0] act, input logic [127:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: got %0h, expected %0h", name, act, exp);
    end
  endtask

  task automatic refresh();
    fifo_empty = (fq.size() == 0);
    fifo_q     = fifo_empty ? '0 : fq[0];
  endtask

  task automatic set_vec(input int i, input int unsigned n,
                         input logic [AW-1:0] a0, input logic [AW-1:0] a1,
                         input logic [AW-1:0] a2, input logic [AW-1:0] a3,
                         input int unsigned nb,
                         input logic [3:0] b0, input logic [3:0] b1,
                         input logic [3:0] b2, input logic [3:0] b3,
                         input logic [3:0] stall, input logic fl,
                         input int unsigned lat, input int unsigned wcyc);
    vecs[i].n     = n;
    vecs[i].addr  = {a3, a2, a1, a0};
    vecs[i].nb    = nb;
    vecs[i].bc    = {b3, b2, b1, b0};
    vecs[i].stall = stall;
    vecs[i].flush = fl;
    vecs[i].lat   = lat;
    vecs[i].wcyc  = wcyc;
  endtask

  // Called at a negedge with the DUT idle; preloads the entries and runs to drained.
  task automatic run_vec(input vec_t v, input string tag);
    logic [31:0]   dat[4];
    logic [3:0]    bes[4];
    logic [AW-1:0] base;
    logic [EW-1:0] tmp;
    exp_t          cur;
    int            e, first_pop, first_wr, wcyc, bi, sc;
    bit            done, pop;
    flush = v.flush;
    for (int i = 0; i < int'(v.n); i++) begin
      dat[i] = $urandom;
      bes[i] = be_ctr;
      be_ctr = be_ctr + 4'h1;
      fq.push_back({bes[i], v.addr[i], dat[i]});
    end
    e = 0;
    for (int b = 0; b < int'(v.nb); b++) begin
      base = v.addr[e];
      for (int k = 0; k < int'(v.bc[b]); k++) begin
        sb.push_back('{base, v.bc[b], bes[e], dat[e]});
        e++;
      end
    end
    refresh();
    first_pop = -1; first_wr = -1; wcyc = 0; bi = 0; sc = 0; done = 0;
    for (int cyc = 0; cyc < 200; cyc++) begin
      avm_waitrequest = v.stall[bi] && (sc < 2);
      #1;
      if (sb.size() == 0 && fq.size() == 0 && drained) begin
        done = 1;
        break;
      end
      if (fifo_rdreq) begin
        chk({tag, "_pop_rule"}, {fifo_empty, avm_write}, 0);
        if (first_pop < 0) first_pop = cyc;
      end
      if (avm_write) begin
        if (first_wr < 0) first_wr = cyc;
        wcyc++;
        if (sb.size() == 0) begin
          chk({tag, "_extra_beat"}, {avm_address, avm_writedata}, 0);
        end else begin
          cur = sb[0];
          chk({tag, "_beat"}, {avm_address, avm_burstcount, avm_byteenable, avm_writedata}, cur);
          if (!avm_waitrequest) begin
            void'(sb.pop_front());
            bi++;
            sc = 0;
            if (bi == int'(cur.bc)) bi = 0;
          end else begin
            sc++;
          end
        end
      end
      pop = fifo_rdreq;
      @(posedge clk);
      #1;
      if (pop) tmp = fq.pop_front();
      refresh();
      @(negedge clk);
    end
    chk({tag, "_done"}, done, 1);
    chk({tag, "_latency"}, 128'(first_wr - first_pop), 128'(v.lat));
    chk({tag, "_write_cycles"}, 128'(wcyc), 128'(v.wcyc));
    chk({tag, "_drained"}, drained, 1);
    sb.delete();
    flush = 1'b0;
    avm_waitrequest = 1'b0;
  endtask

  initial begin
    logic [31:0]   rdat[4];
    logic [EW-1:0] tmp;
    int            acc;
    bit            found, pop;

    set_vec(0, 4, 30'h100, 30'h101, 30'h102, 30'h103, 1, 4, 0, 0, 0, 4'b0000, 0, 5, 4);
    set_vec(1, 3, 30'h100, 30'h101, 30'h200, 30'h0,   2, 2, 1, 0, 0, 4'b0000, 0, 3, 3);
    set_vec(2, 4, 30'h102, 30'h103, 30'h104, 30'h105, 2, 2, 2, 0, 0, 4'b0000, 0, 3, 4);
    set_vec(3, 1, 30'h40,  30'h0,   30'h0,   30'h0,   1, 1, 0, 0, 0, 4'b0000, 0, 4, 1);
    set_vec(4, 4, 30'h100, 30'h101, 30'h102, 30'h103, 1, 4, 0, 0, 0, 4'b1010, 0, 5, 8);
    set_vec(5, 4, 30'h3FFFFFFE, 30'h3FFFFFFF, 30'h0, 30'h1, 2, 2, 2, 0, 0, 4'b0000, 0, 3, 4);
    set_vec(6, 4, 30'h7,   30'h8,   30'h9,   30'hA,   2, 1, 3, 0, 0, 4'b0000, 0, 2, 4);
    set_vec(7, 3, 30'h10,  30'h10,  30'h11,  30'h0,   2, 1, 2, 0, 0, 4'b0000, 0, 2, 3);
    set_vec(8, 2, 30'h20,  30'h21,  30'h0,   30'h0,   2, 1, 1, 0, 0, 4'b0000, 1, 2, 2);
    set_vec(9, 1, 30'h10,  30'h0,   30'h0,   30'h0,   1, 1, 0, 0, 0, 4'b0000, 0, 4, 1);

    rst = 1'b1;
    flush = 1'b0;
    avm_waitrequest = 1'b0;
    refresh();
    repeat (3) @(negedge clk);
    #1;
    chk("reset_outputs", {avm_write, avm_address, avm_writedata, avm_byteenable,
                          avm_burstcount, fifo_rdreq}, 0);
    chk("reset_drained", drained, 1);
    @(negedge clk);
    rst = 1'b0;

    for (int i = 0; i < 9; i++) run_vec(vecs[i], $sformatf("vec%0d", i));

    // Reset while beat 2 of a 4-beat burst is on the bus.
    for (int i = 0; i < 4; i++) begin
      rdat[i] = $urandom;
      fq.push_back({4'hF, 30'(32'h100 + i), rdat[i]});
    end
    refresh();
    acc = 0;
    found = 0;
    for (int cyc = 0; cyc < 50; cyc++) begin
      #1;
      if (avm_write) begin
        if (acc == 2) begin
          found = 1;
          break;
        end
        acc++;
      end
      pop = fifo_rdreq;
      @(posedge clk);
      #1;
      if (pop) tmp = fq.pop_front();
      refresh();
      @(negedge clk);
    end
    chk("rst_seq_reach_beat2", found, 1);
    chk("rst_seq_beat2_data", avm_writedata, rdat[2]);
    rst = 1'b1;
    fq.delete();
    refresh();
    @(posedge clk);
    #1;
    chk("rst_seq_outputs", {avm_write, avm_address, avm_writedata, avm_byteenable,
                            avm_burstcount, fifo_rdreq}, 0);
    chk("rst_seq_drained", drained, 1);
    @(negedge clk);
    rst = 1'b0;
    @(negedge clk);
    run_vec(vecs[9], "post_rst");

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
